// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bus between the fetch/data requesters, the arbiter and memory.
// Signal suffixes are from the arbiter's point of view.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_wmask_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_rdata_o, if_ack_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_wmask_i,
    output dm_rdata_o, dm_ack_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_rdata_o, if_ack_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_wmask_i,
    input  dm_rdata_o, dm_ack_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data accesses win, fetch gets a starvation guard,
// and a flushed fetch completes on the bus but never acknowledges.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_starve_cnt, w_starve_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]  r_mem_wmask, w_mem_wmask_nxt;
  logic        w_if_elig, w_starved, w_if_ack, w_dm_ack;

  assign w_if_elig = bus.if_req_i & ~bus.if_flush_i;
  assign w_starved = (r_starve_cnt == STARVE_LIM);

  always_comb begin
    w_state_nxt     = r_state;
    w_starve_nxt    = r_starve_cnt;
    w_drop_nxt      = r_drop;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wmask_nxt = r_mem_wmask;
    w_if_ack        = 1'b0;
    w_dm_ack        = 1'b0;
    case (r_state)
      IDLE: begin
        w_drop_nxt = 1'b0;
        if (bus.dm_req_i && !(w_if_elig && w_starved)) begin
          w_state_nxt     = BUSY_DM;
          w_mem_we_nxt    = bus.dm_we_i;
          w_mem_addr_nxt  = bus.dm_addr_i;
          w_mem_wdata_nxt = bus.dm_we_i ? bus.dm_wdata_i : 32'h0;
          w_mem_wmask_nxt = bus.dm_we_i ? bus.dm_wmask_i : 4'h0;
          // Count against any waiting fetch, even a flushed one, so the guard is conservative.
          if (!bus.if_req_i)    w_starve_nxt = 4'h0;
          else if (!w_starved)  w_starve_nxt = r_starve_cnt + 4'h1;
        end else if (w_if_elig) begin
          w_state_nxt     = BUSY_IF;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = bus.if_addr_i;
          w_mem_wdata_nxt = 32'h0;
          w_mem_wmask_nxt = 4'h0;
          w_starve_nxt    = 4'h0;
        end
      end
      BUSY_IF: begin
        w_drop_nxt = r_drop | bus.if_flush_i;
        if (bus.mem_ack_i) begin
          w_if_ack    = ~r_drop & ~bus.if_flush_i;
          w_state_nxt = IDLE;
          w_drop_nxt  = 1'b0;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ack_i) begin
          w_dm_ack    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'h0;
      r_drop       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_wmask  <= 4'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_drop       <= w_drop_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_wmask  <= w_mem_wmask_nxt;
    end
  end

  assign bus.mem_req_o   = (r_state != IDLE);
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.mem_wmask_o = r_mem_wmask;
  assign bus.if_ack_o    = w_if_ack;
  assign bus.dm_ack_o    = w_dm_ack;
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.dm_rdata_o  = bus.mem_rdata_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: lone fetch, collision, starvation, flushes, reset mid-access.
module tb_mem_arbiter;
  logic clk, rst;
  int   n_chk, n_err;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_flush_i = 0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = 0;
    bus.dm_wdata_i = 0; bus.dm_wmask_i = 0;
    bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
    tick; tick;

    // reset state
    chk("rst_mem_req", 32'(bus.mem_req_o), 0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    chk("rst_mem_wmask", 32'(bus.mem_wmask_o), 0);
    chk("rst_acks", {30'h0, bus.if_ack_o, bus.dm_ack_o}, 0);
    rst = 1'b0;

    // lone fetch, memory answers 3 cycles after the request appears
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    tick;
    chk("lf_req", 32'(bus.mem_req_o), 1);
    chk("lf_addr", bus.mem_addr_o, 32'h100);
    tick; tick;
    chk("lf_wait_ack", 32'(bus.if_ack_o), 0);
    tick;
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h00500093;
    #2;
    chk("lf_ack", 32'(bus.if_ack_o), 1);
    chk("lf_rdata", bus.if_rdata_o, 32'h00500093);
    chk("lf_dm_ack", 32'(bus.dm_ack_o), 0);
    tick;
    bus.mem_ack_i = 0; bus.if_req_i = 0;
    #2;
    chk("lf_idle", 32'(bus.mem_req_o), 0);
    chk("lf_ack_1cyc", 32'(bus.if_ack_o), 0);

    // collision: store wins first, fetch follows
    bus.if_req_i = 1; bus.if_addr_i = 32'h104;
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 32'h2000;
    bus.dm_wdata_i = 32'hDEADBEEF; bus.dm_wmask_i = 4'b0011;
    tick;
    chk("col_dm_addr", bus.mem_addr_o, 32'h2000);
    chk("col_dm_we", 32'(bus.mem_we_o), 1);
    chk("col_dm_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
    chk("col_dm_wmask", 32'(bus.mem_wmask_o), 32'b0011);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h11;
    #2;
    chk("col_dm_ack", {30'h0, bus.if_ack_o, bus.dm_ack_o}, 32'b01);
    tick;
    bus.mem_ack_i = 0; bus.dm_req_i = 0; bus.dm_we_i = 0;
    tick;
    chk("col_if_addr", bus.mem_addr_o, 32'h104);
    chk("col_if_we", 32'(bus.mem_we_o), 0);
    chk("col_if_wdata", bus.mem_wdata_o, 0);
    chk("col_if_wmask", 32'(bus.mem_wmask_o), 0);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h22;
    #2;
    chk("col_if_ack", {30'h0, bus.if_ack_o, bus.dm_ack_o}, 32'b10);
    tick;
    bus.mem_ack_i = 0; bus.if_req_i = 0;

    // starvation: 4 loads, then the waiting fetch
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h3000;
    bus.dm_wdata_i = 32'hFFFF_FFFF; bus.dm_wmask_i = 4'hF;
    bus.if_req_i = 1; bus.if_addr_i = 32'h200;
    for (int g = 0; g < 5; g++) begin
      tick;
      chk($sformatf("stv_addr%0d", g), bus.mem_addr_o, (g < 4) ? 32'h3000 : 32'h200);
      chk($sformatf("stv_wmask%0d", g), 32'(bus.mem_wmask_o), 0);
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'(g + 32'hA0);
      #2;
      chk($sformatf("stv_ack%0d", g), {30'h0, bus.if_ack_o, bus.dm_ack_o},
          (g < 4) ? 32'b01 : 32'b10);
      if (g < 4) chk($sformatf("stv_rdata%0d", g), bus.dm_rdata_o, 32'(g + 32'hA0));
      tick;
      bus.mem_ack_i = 0;
    end
    chk("stv_cnt_clr", 32'(dut.r_starve_cnt), 0);
    bus.dm_req_i = 0; bus.if_req_i = 0;
    tick;

    // flushed fetch request in IDLE is not granted
    bus.if_req_i = 1; bus.if_flush_i = 1; bus.if_addr_i = 32'h2F0;
    tick;
    chk("fl_idle_nogrant", 32'(bus.mem_req_o), 0);
    bus.if_flush_i = 0; bus.if_req_i = 0;
    tick;

    // flush in flight: transaction completes silently, then new address
    bus.if_req_i = 1; bus.if_addr_i = 32'h300;
    tick;
    chk("fif_addr", bus.mem_addr_o, 32'h300);
    tick;
    bus.if_flush_i = 1;
    tick;
    bus.if_flush_i = 0; bus.if_addr_i = 32'h400;
    chk("fif_req_held", 32'(bus.mem_req_o), 1);
    chk("fif_addr_stable", bus.mem_addr_o, 32'h300);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h33;
    #2;
    chk("fif_no_ack", 32'(bus.if_ack_o), 0);
    tick;
    bus.mem_ack_i = 0;
    tick;
    chk("fif_new_addr", bus.mem_addr_o, 32'h400);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h44;
    #2;
    chk("fif_new_ack", 32'(bus.if_ack_o), 1);
    tick;
    bus.mem_ack_i = 0; bus.if_req_i = 0;

    // flush in the ack cycle
    bus.if_req_i = 1; bus.if_addr_i = 32'h500;
    tick;
    bus.mem_ack_i = 1; bus.if_flush_i = 1; bus.mem_rdata_i = 32'h55;
    #2;
    chk("fac_no_ack", 32'(bus.if_ack_o), 0);
    tick;
    bus.mem_ack_i = 0; bus.if_flush_i = 0; bus.if_req_i = 0;
    chk("fac_idle", 32'(bus.mem_req_o), 0);
    chk("fac_drop_clr", 32'(dut.r_drop), 0);

    // reset while BUSY_DM, late ack ignored
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 32'h600;
    bus.dm_wdata_i = 32'h1234_5678; bus.dm_wmask_i = 4'hF;
    tick;
    chk("rb_req", 32'(bus.mem_req_o), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0; bus.dm_req_i = 0; bus.dm_we_i = 0;
    chk("rb_mem_req", 32'(bus.mem_req_o), 0);
    chk("rb_mem_we", 32'(bus.mem_we_o), 0);
    chk("rb_mem_addr", bus.mem_addr_o, 0);
    chk("rb_mem_wdata", bus.mem_wdata_o, 0);
    chk("rb_mem_wmask", 32'(bus.mem_wmask_o), 0);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h66;
    #2;
    chk("rb_no_ack", {30'h0, bus.if_ack_o, bus.dm_ack_o}, 0);
    tick;
    bus.mem_ack_i = 0;
    chk("rb_still_idle", 32'(bus.mem_req_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
